fib_bcd_conv: RTL and testbench

- Downstream stage of the Fibonacci generator; consumes its WIDTH-bit binary result.
- Converts the result to packed BCD with a sequential shift-and-add-3 (double-dabble) engine, one bit per clock.
- Uses a strobe/busy handshake on the input side and a one-cycle valid pulse on the output side.
- Output feeds the display/IO logic in the top-level wrapper.

---
 rtl/fib_bcd_conv.sv | 104 ++++++++++
 tb/tb_fib_bcd_conv.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fib_bcd_conv.sv
// Sequential binary-to-packed-BCD converter (double-dabble), one input bit per clock.
// Sits behind the Fibonacci generator and feeds the display logic.
module fib_bcd_conv #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_stb,
    input  logic [WIDTH-1:0]      i_bin,
    output logic                  o_busy,
    output logic                  o_valid,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic                  o_state
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    // Handshake: a conversion starts on any rising edge where state is IDLE and
    // i_stb=1 (o_busy=0 in that cycle). Strobes while o_busy=1 are dropped, not
    // queued. o_valid is a one-cycle pulse; the state is IDLE during it, so a
    // strobe in the o_valid cycle is accepted.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic [WIDTH-1:0]   bin_q, bin_n;
    logic [BCD_W-1:0]   scr_q, scr_n;
    logic [BCD_W-1:0]   bcd_n;
    logic               valid_n;
    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   scr_shift;
    logic [WIDTH-1:0]   bin_shift;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            scr_q   <= '0;
            o_bcd   <= '0;
            o_valid <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            bin_q   <= bin_n;
            scr_q   <= scr_n;
            o_bcd   <= bcd_n;
            o_valid <= valid_n;
        end
    end

    // Per-digit add-3 with no carry between digits, then one combined left shift.
    always_comb begin
        adj = scr_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (scr_q[4*d +: 4] >= 4'd5) begin
                adj[4*d +: 4] = scr_q[4*d +: 4] + 4'd3;
            end
        end
        scr_shift = {adj[BCD_W-2:0], bin_q[WIDTH-1]};
        bin_shift = bin_q << 1;
    end

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        bin_n   = bin_q;
        scr_n   = scr_q;
        bcd_n   = o_bcd;
        valid_n = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_stb) begin
                    bin_n   = i_bin;
                    scr_n   = '0;
                    cnt_n   = '0;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                scr_n = scr_shift;
                bin_n = bin_shift;
                cnt_n = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    bcd_n   = scr_shift;
                    valid_n = 1'b1;
                    cnt_n   = '0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign o_busy  = (state_q == SHIFT);
    assign o_state = state_q;

endmodule

// File: tb/tb_fib_bcd_conv.sv
// Self-checking bench for fib_bcd_conv: directed scenarios plus a shuffled
// full sweep, checked against a decimal-arithmetic reference.
module tb_fib_bcd_conv;

    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;
    localparam int BCD_W  = 4 * DIGITS;

    logic              clk;
    logic              reset_n;
    logic              stb;
    logic [WIDTH-1:0]  bin;
    logic              busy;
    logic              valid;
    logic [BCD_W-1:0]  bcd;
    logic              state;

    int checks   = 0;
    int failures = 0;

    logic [BCD_W-1:0] exp_q[$];

    fib_bcd_conv #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .i_stb     (stb),
        .i_bin     (bin),
        .o_busy    (busy),
        .o_valid   (valid),
        .o_bcd     (bcd),
        .o_state   (state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [BCD_W-1:0] ref_bcd(input int v);
        logic [BCD_W-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Strobe one value, then wait (bounded) for o_valid. lat counts cycles
    // after the accepting edge; busy_cycles counts cycles with o_busy=1 before
    // the pulse. With noise, i_bin churns and stray strobes land mid-conversion.
    task automatic run_conv(input logic [WIDTH-1:0] v, input bit noise,
                            output logic [BCD_W-1:0] res, output int lat,
                            output int busy_cycles);
        bin = v;
        stb = 1'b1;
        @(negedge clk);
        stb = 1'b0;
        lat = -1;
        busy_cycles = 0;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            if (valid) begin
                lat = k;
                break;
            end
            if (busy) busy_cycles++;
            if (noise) begin
                bin = WIDTH'($urandom);
                stb = (k < 6) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
        stb = 1'b0;
        res = bcd;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        stb = 1'b0;
        bin = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || bcd !== '0 || state !== 1'b0) begin
            failures++;
            $display("FAIL reset: busy=%b valid=%b bcd=%h state=%b, required 0 0 000 0",
                     busy, valid, bcd, state);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zero();
        logic [BCD_W-1:0] r;
        int lat, bc;
        run_conv('0, 1'b0, r, lat, bc);
        checks++;
        if (lat !== WIDTH) begin
            failures++;
            $display("FAIL zero_latency: got %0d required %0d", lat, WIDTH);
        end
        checks++;
        if (bc !== WIDTH) begin
            failures++;
            $display("FAIL zero_busy_cycles: got %0d required %0d", bc, WIDTH);
        end
        checks++;
        if (r !== ref_bcd(0) || busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_result: bcd=%h busy=%b required bcd=%h busy=0", r, busy, ref_bcd(0));
        end
        @(negedge clk);
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL zero_valid_pulse: valid=%b one cycle later, required 0", valid);
        end
    endtask

    task automatic test_values();
        int vals[3] = '{233, 255, 144};
        logic [BCD_W-1:0] r;
        int lat, bc;
        foreach (vals[i]) begin
            run_conv(WIDTH'(vals[i]), 1'b0, r, lat, bc);
            checks++;
            if (r !== ref_bcd(vals[i]) || lat !== WIDTH) begin
                failures++;
                $display("FAIL value_%0d: bcd=%h lat=%0d required bcd=%h lat=%0d",
                         vals[i], r, lat, ref_bcd(vals[i]), WIDTH);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ignored_strobe();
        int pulses;
        logic [BCD_W-1:0] seen;
        pulses = 0;
        seen = '0;
        bin = WIDTH'(89);
        stb = 1'b1;
        @(negedge clk);
        stb = 1'b0;
        repeat (3) @(negedge clk);
        bin = WIDTH'(13);
        stb = 1'b1;
        @(negedge clk);
        stb = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (valid) begin
                pulses++;
                seen = bcd;
            end
        end
        checks++;
        if (pulses !== 1) begin
            failures++;
            $display("FAIL ignored_strobe_pulses: got %0d required 1", pulses);
        end
        checks++;
        if (seen !== ref_bcd(89)) begin
            failures++;
            $display("FAIL ignored_strobe_result: bcd=%h required %h", seen, ref_bcd(89));
        end
    endtask

    task automatic test_back_to_back();
        int got, next_val, bad_busy, prev_k, bad_gap;
        logic [BCD_W-1:0] e;
        got = 0;
        bad_busy = 0;
        bad_gap = 0;
        prev_k = -1;
        exp_q.delete();
        for (int v = 1; v <= 3; v++) exp_q.push_back(ref_bcd(v));
        next_val = 2;
        bin = WIDTH'(1);
        stb = 1'b1;
        for (int k = 0; k < 60 && got < 3; k++) begin
            @(negedge clk);
            if (busy === valid) bad_busy++;
            if (valid) begin
                e = exp_q.pop_front();
                checks++;
                if (bcd !== e) begin
                    failures++;
                    $display("FAIL back_to_back_%0d: bcd=%h required %h", got, bcd, e);
                end
                // first pulse is WIDTH cycles after acceptance at k=0;
                // each later one is WIDTH cycles after its o_valid-cycle accept
                if (prev_k < 0 ? (k != WIDTH) : (k - prev_k != WIDTH + 1)) bad_gap++;
                prev_k = k;
                got++;
                if (got < 3) bin = WIDTH'(next_val);
                next_val++;
                if (got == 3) stb = 1'b0;
            end
        end
        stb = 1'b0;
        checks++;
        if (got !== 3) begin
            failures++;
            $display("FAIL back_to_back_count: got %0d pulses required 3", got);
        end
        checks++;
        if (bad_busy !== 0 || bad_gap !== 0) begin
            failures++;
            $display("FAIL back_to_back_timing: busy/valid overlap=%0d latency errors=%0d required 0 0",
                     bad_busy, bad_gap);
        end
        @(negedge clk);
        while (busy) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_abort();
        int pulses;
        logic [BCD_W-1:0] r;
        int lat, bc;
        pulses = 0;
        bin = WIDTH'(55);
        stb = 1'b1;
        @(negedge clk);
        stb = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        stb = 1'b1;
        bin = WIDTH'(99);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || bcd !== '0) begin
            failures++;
            $display("FAIL abort_state: busy=%b valid=%b bcd=%h required 0 0 000", busy, valid, bcd);
        end
        reset_n = 1'b1;
        stb = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (valid || busy) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            failures++;
            $display("FAIL abort_quiet: %0d cycles with busy/valid after abort, required 0", pulses);
        end
        run_conv(WIDTH'(21), 1'b0, r, lat, bc);
        checks++;
        if (r !== ref_bcd(21) || lat !== WIDTH) begin
            failures++;
            $display("FAIL abort_restart: bcd=%h lat=%0d required %h %0d", r, lat, ref_bcd(21), WIDTH);
        end
        @(negedge clk);
    endtask

    task automatic test_sweep();
        int order[256];
        int j, tmp, lat, bc, bad_val, bad_digit, bad_lat;
        logic [BCD_W-1:0] r;
        bad_val = 0;
        bad_digit = 0;
        bad_lat = 0;
        for (int i = 0; i < 256; i++) order[i] = i;
        for (int i = 255; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = order[i];
            order[i] = order[j];
            order[j] = tmp;
        end
        for (int i = 0; i < 256; i++) begin
            run_conv(WIDTH'(order[i]), 1'b1, r, lat, bc);
            checks++;
            if (r !== ref_bcd(order[i])) begin
                failures++;
                bad_val++;
                if (bad_val <= 5)
                    $display("FAIL sweep_value: in=%0d bcd=%h required %h", order[i], r, ref_bcd(order[i]));
            end
            for (int d = 0; d < DIGITS; d++) begin
                checks++;
                if (r[4*d +: 4] > 4'd9) begin
                    failures++;
                    bad_digit++;
                    if (bad_digit <= 5)
                        $display("FAIL sweep_digit: in=%0d digit%0d=%0d required <=9", order[i], d, r[4*d +: 4]);
                end
            end
            checks++;
            if (lat !== WIDTH || bc !== WIDTH) begin
                failures++;
                bad_lat++;
                if (bad_lat <= 5)
                    $display("FAIL sweep_latency: in=%0d lat=%0d busy=%0d required %0d %0d",
                             order[i], lat, bc, WIDTH, WIDTH);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        stb = 1'b0;
        bin = '0;
        test_reset();
        test_zero();
        test_values();
        test_ignored_strobe();
        test_back_to_back();
        test_abort();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
